// File: rtl/ahb_master_if.sv
// ahb_master_if: AHB master. Turns single/INCR burst commands from a local
// user port into pipelined AHB address/data phases, handling arbitration,
// wait states and OKAY/ERROR/RETRY/SPLIT responses.
//   hclk, hresetn          clock; synchronous active-high reset
//   cmd_* / cmd_ready      user command port (write, addr, len = beats-1)
//   wr_data / wr_pop       write data stream; wr_pop marks a consumed beat
//   rd_data / rd_valid     read data stream, one pulse per beat
//   done / err             end-of-command pulse; err flags an ERROR abort
//   hbusreq / hgrant       arbiter handshake
//   haddr..hwdata          AHB master outputs; hrdata/hready/hresp inputs
module ahb_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              hbusreq,
  input  logic              hgrant,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_RESP2 = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  logic [2:0]        state, state_d;
  logic              cmd_ready_d, hbusreq_d, hwrite_d, rd_valid_d, done_d, err_d;
  logic [ADDR_W-1:0] haddr_d;
  logic [1:0]        htrans_d;
  logic [2:0]        hburst_d;
  logic [DATA_W-1:0] hwdata_d, rd_data_d;
  logic [3:0]        len_q, len_d;
  logic [CNT_W-1:0]  idx_q, idx_d;            // next beat to put on the address bus
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d; // its address
  logic              dp_valid_q, dp_valid_d;  // a data phase is in flight
  logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
  logic [3:0]        dp_idx_q, dp_idx_d;
  logic              replay_q, replay_d;      // retried write beat: reuse held hwdata

  logic addr_acc, data_ok, resp_first, remain;

  assign hsize      = 3'b010;
  assign addr_acc   = htrans[1] & hready;
  assign data_ok    = dp_valid_q & hready & (hresp == RESP_OKAY);
  assign resp_first = dp_valid_q & ~hready & (hresp != RESP_OKAY);
  assign remain     = (idx_q <= {1'b0, len_q});

  // Combinational so the user can advance wr_data on the edge the beat is captured.
  assign wr_pop = addr_acc & hwrite & ~replay_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    cmd_ready_d = cmd_ready;
    hbusreq_d   = hbusreq;
    haddr_d     = haddr;
    htrans_d    = htrans;
    hwrite_d    = hwrite;
    hburst_d    = hburst;
    hwdata_d    = hwdata;
    rd_data_d   = rd_data;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    len_d       = len_q;
    idx_d       = idx_q;
    pend_addr_d = pend_addr_q;
    dp_valid_d  = dp_valid_q;
    dp_addr_d   = dp_addr_q;
    dp_idx_d    = dp_idx_q;
    replay_d    = replay_q;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          hbusreq_d   = 1'b1;
          hwrite_d    = cmd_write;
          hburst_d    = (cmd_len == 4'd0) ? BURST_SINGLE : BURST_INCR;
          len_d       = cmd_len;
          idx_d       = '0;
          pend_addr_d = cmd_addr;
          dp_valid_d  = 1'b0;
          replay_d    = 1'b0;
          state_d     = S_REQ;
        end
      end

      S_REQ, S_XFER: begin
        if (resp_first) begin
          // First cycle of a two-cycle response: cancel the pipelined address.
          htrans_d = TR_IDLE;
          state_d  = S_RESP2;
        end else begin
          if (data_ok) begin
            dp_valid_d = 1'b0;
            if (!hwrite) begin
              rd_data_d  = hrdata;
              rd_valid_d = 1'b1;
            end
            if ((dp_idx_q == len_q) && !remain) begin
              done_d  = 1'b1;
              state_d = S_FIN;
            end
          end
          if (state == S_REQ) begin
            if (hready && hgrant) begin
              haddr_d     = pend_addr_q;
              htrans_d    = TR_NONSEQ;
              pend_addr_d = pend_addr_q + ADDR_W'(4);
              idx_d       = idx_q + CNT_W'(1);
              state_d     = S_XFER;
            end
          end else if (addr_acc) begin
            dp_valid_d = 1'b1;
            dp_addr_d  = haddr;
            dp_idx_d   = 4'(idx_q - CNT_W'(1));
            if (hwrite) begin
              if (replay_q) replay_d = 1'b0;
              else          hwdata_d = wr_data;
            end
            if (!remain) begin
              htrans_d  = TR_IDLE;
              hbusreq_d = 1'b0;
            end else if (hgrant) begin
              haddr_d     = pend_addr_q;
              htrans_d    = TR_SEQ;
              pend_addr_d = pend_addr_q + ADDR_W'(4);
              idx_d       = idx_q + CNT_W'(1);
            end else begin
              // Bus lost with beats left: re-arbitrate and resume with NONSEQ.
              htrans_d = TR_IDLE;
              state_d  = S_REQ;
            end
          end
        end
      end

      S_RESP2: begin
        if (hready) begin
          dp_valid_d = 1'b0;
          if (hresp == RESP_ERROR) begin
            hbusreq_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            state_d   = S_FIN;
          end else begin
            // RETRY/SPLIT: rewind to the failed beat and re-request the bus.
            idx_d       = {1'b0, dp_idx_q};
            pend_addr_d = dp_addr_q;
            replay_d    = hwrite;
            hbusreq_d   = 1'b1;
            state_d     = S_REQ;
          end
        end
      end

      S_FIN: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        htrans_d    = TR_IDLE;
        hbusreq_d   = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      hbusreq     <= 1'b0;
      haddr       <= '0;
      htrans      <= TR_IDLE;
      hwrite      <= 1'b0;
      hburst      <= BURST_SINGLE;
      hwdata      <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      pend_addr_q <= '0;
      dp_valid_q  <= 1'b0;
      dp_addr_q   <= '0;
      dp_idx_q    <= '0;
      replay_q    <= 1'b0;
    end else begin
      state       <= state_d;
      cmd_ready   <= cmd_ready_d;
      hbusreq     <= hbusreq_d;
      haddr       <= haddr_d;
      htrans      <= htrans_d;
      hwrite      <= hwrite_d;
      hburst      <= hburst_d;
      hwdata      <= hwdata_d;
      rd_data     <= rd_data_d;
      rd_valid    <= rd_valid_d;
      done        <= done_d;
      err         <= err_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      pend_addr_q <= pend_addr_d;
      dp_valid_q  <= dp_valid_d;
      dp_addr_q   <= dp_addr_d;
      dp_idx_q    <= dp_idx_d;
      replay_q    <= replay_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if: the bench plays arbiter and slave cycle by
// cycle; expected values are hand-computed per edge.
module tb_ahb_master_if;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wr_data, rd_data, hwdata, hrdata, haddr;
  logic        wr_pop, rd_valid, done, err, hbusreq, hgrant, hwrite, hready;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;

  int vectors = 0;
  int miscompares = 0;
  int pop_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int p0, r0, d0;

  ahb_master_if #(.ADDR_W(32), .DATA_W(32)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .hbusreq(hbusreq), .hgrant(hgrant),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  // Pulse counters for wr_pop / rd_valid / done.
  always @(posedge hclk) begin
    if (wr_pop)   pop_cnt  <= pop_cnt + 1;
    if (rd_valid) rd_cnt   <= rd_cnt + 1;
    if (done)     done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  initial begin
    hresetn = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; hgrant = 1'b1; hrdata = '0; hready = 1'b1; hresp = 2'b00;
    step(); step();

    // Reset state
    chk("rst_htrans",  32'(htrans), 32'd0);
    chk("rst_haddr",   haddr, 32'd0);
    chk("rst_hbusreq", 32'(hbusreq), 32'd0);
    chk("rst_hsize",   32'(hsize), 32'd2);
    chk("rst_hburst",  32'(hburst), 32'd0);
    chk("rst_hwdata",  hwdata, 32'd0);
    chk("rst_cmd_rdy", 32'(cmd_ready), 32'd1);
    chk("rst_done",    32'({done, err, rd_valid, hwrite, wr_pop}), 32'd0);
    hresetn = 1'b0;
    step();

    // Single write, 0x10 <- DEADBEEF
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_len = 4'd0;
    wr_data = 32'hDEAD_BEEF; p0 = pop_cnt;
    step();                                     // accept
    cmd_valid = 1'b0;
    chk("w1_cmd_rdy", 32'(cmd_ready), 32'd0);
    chk("w1_busreq",  32'(hbusreq), 32'd1);
    chk("w1_req_idle", 32'(htrans), 32'd0);
    step();                                     // NONSEQ 0x10
    chk("w1_nonseq", 32'(htrans), 32'd2);
    chk("w1_haddr",  haddr, 32'h10);
    chk("w1_hwrite", 32'(hwrite), 32'd1);
    chk("w1_hburst", 32'(hburst), 32'd0);
    chk("w1_wr_pop", 32'(wr_pop), 32'd1);
    step();                                     // data phase
    chk("w1_hwdata", hwdata, 32'hDEAD_BEEF);
    chk("w1_idle",   32'(htrans), 32'd0);
    chk("w1_busrel", 32'(hbusreq), 32'd0);
    chk("w1_nodone", 32'(done), 32'd0);
    step();                                     // 4th cycle after accept
    chk("w1_done", 32'({done, err}), 32'b10);
    step();
    chk("w1_done_end", 32'(done), 32'd0);
    chk("w1_rdy_back", 32'(cmd_ready), 32'd1);
    chk("w1_pops", 32'(pop_cnt - p0), 32'd1);

    // INCR read len=3 at 0x100, two waits on beat 2
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100; cmd_len = 4'd3; r0 = rd_cnt;
    step();
    cmd_valid = 1'b0;
    step();
    chk("r4_a0", {haddr[29:0], htrans}, {30'h100, 2'b10});
    chk("r4_burst", 32'(hburst), 32'd1);
    step();
    chk("r4_a1", {haddr[29:0], htrans}, {30'h104, 2'b11});
    hrdata = 32'hA000_0000;
    step();
    chk("r4_d0", rd_data, 32'hA000_0000);
    chk("r4_a2", {haddr[29:0], htrans}, {30'h108, 2'b11});
    hrdata = 32'hA000_0001;
    step();
    chk("r4_d1", rd_data, 32'hA000_0001);
    chk("r4_a3", {haddr[29:0], htrans}, {30'h10C, 2'b11});
    hready = 1'b0; hrdata = 32'hBAD0_BAD0;
    step();
    chk("r4_wait1", {haddr[29:0], htrans}, {30'h10C, 2'b11});
    chk("r4_wait1_rv", 32'(rd_valid), 32'd0);
    step();
    chk("r4_wait2", {haddr[29:0], htrans}, {30'h10C, 2'b11});
    hready = 1'b1; hrdata = 32'hA000_0002;
    step();
    chk("r4_d2", {31'(rd_data), rd_valid}, {31'h2000_0002, 1'b1});
    chk("r4_last_idle", 32'({htrans, hbusreq}), 32'd0);
    hrdata = 32'hA000_0003;
    step();
    chk("r4_d3", rd_data, 32'hA000_0003);
    chk("r4_done", 32'({done, err}), 32'b10);
    step();
    chk("r4_rd_cnt", 32'(rd_cnt - r0), 32'd4);

    // Write burst len=3 at 0x100, RETRY on beat 1
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_len = 4'd3;
    wr_data = 32'hC000_0000; p0 = pop_cnt;
    step();
    cmd_valid = 1'b0;
    step();
    chk("rt_a0", {haddr[29:0], htrans}, {30'h100, 2'b10});
    step();
    wr_data = 32'hC000_0001;
    chk("rt_hw0", hwdata, 32'hC000_0000);
    step();
    chk("rt_hw1", hwdata, 32'hC000_0001);
    chk("rt_a2", {haddr[29:0], htrans}, {30'h108, 2'b11});
    wr_data = 32'hC000_0002; hready = 1'b0; hresp = 2'b10;
    #1 chk("rt_nopop_resp", 32'(wr_pop), 32'd0);
    step();
    chk("rt_cancel", 32'(htrans), 32'd0);
    hready = 1'b1;
    step();
    chk("rt_idle2", 32'(htrans), 32'd0);
    chk("rt_rereq", 32'(hbusreq), 32'd1);
    hresp = 2'b00;
    step();
    chk("rt_restart", {haddr[29:0], htrans}, {30'h104, 2'b10});
    chk("rt_held", hwdata, 32'hC000_0001);
    #1 chk("rt_replay_nopop", 32'(wr_pop), 32'd0);
    step();
    chk("rt_a2b", {haddr[29:0], htrans}, {30'h108, 2'b11});
    chk("rt_held2", hwdata, 32'hC000_0001);
    step();
    chk("rt_hw2", hwdata, 32'hC000_0002);
    wr_data = 32'hC000_0003;
    step();
    chk("rt_hw3", hwdata, 32'hC000_0003);
    step();
    chk("rt_done", 32'({done, err}), 32'b10);
    chk("rt_pops", 32'(pop_cnt - p0), 32'd4);
    step();

    // Read len=1 at 0x200, ERROR on beat 0
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; cmd_len = 4'd1; r0 = rd_cnt;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("er_a1", {haddr[29:0], htrans}, {30'h204, 2'b11});
    hready = 1'b0; hresp = 2'b01;
    step();
    chk("er_cancel", 32'(htrans), 32'd0);
    hready = 1'b1;
    step();
    chk("er_done", 32'({done, err}), 32'b11);
    chk("er_idle", 32'({htrans, hbusreq}), 32'd0);
    hresp = 2'b00;
    step();
    chk("er_done_end", 32'({done, err}), 32'd0);
    chk("er_rd_cnt", 32'(rd_cnt - r0), 32'd0);
    chk("er_rdy", 32'(cmd_ready), 32'd1);

    // Read len=3 at 0x300, grant lost after beat 1
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h300; cmd_len = 4'd3; r0 = rd_cnt;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("gl_a1", {haddr[29:0], htrans}, {30'h304, 2'b11});
    hgrant = 1'b0; hrdata = 32'hD000_0000;
    step();
    chk("gl_idle", 32'(htrans), 32'd0);
    chk("gl_busreq", 32'(hbusreq), 32'd1);
    chk("gl_d0", rd_data, 32'hD000_0000);
    hrdata = 32'hD000_0001;
    step();
    chk("gl_wait", 32'({htrans, hbusreq}), 32'd1);
    chk("gl_d1", rd_data, 32'hD000_0001);
    hgrant = 1'b1;
    step();
    chk("gl_resume", {haddr[29:0], htrans}, {30'h308, 2'b10});
    step();
    chk("gl_a3", {haddr[29:0], htrans}, {30'h30C, 2'b11});
    hrdata = 32'hD000_0002;
    step();
    chk("gl_d2", rd_data, 32'hD000_0002);
    hrdata = 32'hD000_0003;
    step();
    chk("gl_d3", rd_data, 32'hD000_0003);
    chk("gl_done", 32'({done, err}), 32'b10);
    step();
    chk("gl_rd_cnt", 32'(rd_cnt - r0), 32'd4);

    // Reset in the middle of a write burst
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h400; cmd_len = 4'd3;
    wr_data = 32'hE000_0000;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("mr_a1", {haddr[29:0], htrans}, {30'h404, 2'b11});
    hresetn = 1'b1; d0 = done_cnt;
    step();
    chk("mr_bus", 32'({htrans, hbusreq, hwrite, hburst}), 32'd0);
    chk("mr_haddr", haddr, 32'd0);
    chk("mr_hwdata", hwdata, 32'd0);
    chk("mr_hsize", 32'(hsize), 32'd2);
    chk("mr_rdy", 32'(cmd_ready), 32'd1);
    chk("mr_flags", 32'({done, err, rd_valid, wr_pop}), 32'd0);
    hresetn = 1'b0;
    step(); step(); step();
    chk("mr_nodone", 32'(done_cnt - d0), 32'd0);
    chk("mr_idle", 32'({htrans, hbusreq}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
